// File: rtl/iter_divider_pkg.sv
// iter_divider_pkg: shared types and sizing for the iterative divider
package iter_divider_pkg;
    localparam int DIV_W = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W);
    typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
endpackage

// File: rtl/iter_divider_div_step.sv
// iter_divider_div_step: one combinational restoring-division step
module iter_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] sh, trial;
    always_comb begin
        sh = {rem, quo[WIDTH-1]};
        trial = sh - {1'b0, div};
        rem_next = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end
endmodule

// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional DIV_EARLY_OUT_EN finishes at once when |dividend| < |divisor|.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = (WIDTH == DIV_W) ? DIV_CNT_W : $clog2(WIDTH);
    div_state_t state, next;
    div_op_t op_e;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] rem_r, quo_r, div_r, rem_n, quo_n;
    logic [WIDTH-1:0] abs_a, abs_b, spec_res, fin_res;
    logic is_rem, neg_q, neg_r;
    logic sgn, want_rem, a_neg, b_neg, div0, ovf, early, special, accept;

    iter_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem_r), .quo(quo_r), .div(div_r), .rem_next(rem_n), .quo_next(quo_n)
    );

    always_comb begin
        op_e = div_op_t'(op);
        sgn = (op_e == DIV) || (op_e == REM);
        want_rem = (op_e == REM) || (op_e == REMU);
        a_neg = sgn && dividend[WIDTH-1];
        b_neg = sgn && divisor[WIDTH-1];
        abs_a = a_neg ? -dividend : dividend;
        abs_b = b_neg ? -divisor : divisor;
        div0 = divisor == '0;
        ovf = sgn && dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1;
`ifdef DIV_EARLY_OUT_EN
        early = abs_a < abs_b;
`else
        early = 1'b0;
`endif
        special = div0 || ovf || early;
        // early-out leaves quotient 0 and the original dividend as remainder
        spec_res = div0 ? (want_rem ? dividend : '1) :
                   ovf  ? (want_rem ? '0 : dividend) :
                          (want_rem ? dividend : '0);
        fin_res = is_rem ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
        accept = start && ready && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        if (flush) next = IDLE;
        else if (accept) next = special ? DONE : BUSY;
        else if (state == BUSY) next = (cnt == '0) ? DONE : BUSY;
        else if (state == DONE) next = IDLE;
    end

    always_comb begin
        ready = (state == IDLE) || (state == DONE);
        busy = state == BUSY;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            rem_r <= '0;
            quo_r <= '0;
            div_r <= '0;
            is_rem <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            result <= '0;
        end else if (accept) begin
            cnt <= CW'(WIDTH - 1);
            rem_r <= '0;
            quo_r <= abs_a;
            div_r <= abs_b;
            is_rem <= want_rem;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (special) result <= spec_res;
        end else if (busy && !flush) begin
            cnt <= cnt - CW'(1);
            rem_r <= rem_n;
            quo_r <= quo_n;
            if (cnt == '0) result <= fin_res;
        end
    end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: model-checked directed test of iter_divider
module tb_iter_divider;
    localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = W + 1;
`endif
    logic clk = 0, rst_n = 0, start = 0, flush = 0;
    logic [1:0] op = 0;
    logic [W-1:0] dividend = 0, divisor = 0;
    logic ready, busy, done;
    logic [W-1:0] result;

    iter_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
        .dividend(dividend), .divisor(divisor),
        .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    typedef struct {int acc; int due; int fl; logic [W-1:0] res;} exp_t;
    exp_t q[$];
    logic [W-1:0] last_res = 0, dut_res = 0, er;
    logic eb, ed;
    int done_cyc = -1;

    function automatic logic [W-1:0] model(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
        if (b == 0) return o[1] ? a : '1;
        if (!o[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1) return o[1] ? '0 : a;
        if (o[0]) return o[1] ? a % b : a / b;
        return W'(o[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b));
    endfunction

    function automatic int latency(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] ma, mb;
        if (b == 0 || (!o[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1)) return 1;
        ma = (!o[0] && a[W-1]) ? -a : a;
        mb = (!o[0] && b[W-1]) ? -b : b;
        if (ma < mb) return EO_LAT;
        return W + 1;
    endfunction

    task automatic check(string name, logic [W-1:0] got, logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        eb = 0;
        ed = 0;
        er = last_res;
        foreach (q[i]) begin
            if (cyc > q[i].acc && cyc < q[i].due && (q[i].fl < 0 || cyc <= q[i].fl)) eb = 1;
            if (cyc == q[i].due && q[i].fl < 0) begin
                ed = 1;
                er = q[i].res;
            end
        end
        check("done", W'(done), W'(ed));
        check("busy", W'(busy), W'(eb));
        check("ready", W'(ready), W'(!eb));
        check("result", result, er);
        if (ed) begin
            last_res = er;
            dut_res = result;
            done_cyc = cyc;
        end
        while (q.size() > 0 && (cyc >= q[0].due || (q[0].fl >= 0 && cyc >= q[0].fl))) void'(q.pop_front());
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int t);
        @(posedge clk);
        #2;
        start = 1;
        op = o;
        dividend = a;
        divisor = b;
        t = cyc;
        done_cyc = -1;
        dut_res = 'x;
        q.push_back('{acc: cyc, due: cyc + latency(o, a, b), fl: -1, res: model(o, a, b)});
        @(posedge clk);
        #2;
        start = 0;
        op = 2'($urandom);
        dividend = $urandom;
        divisor = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && q.size() > 0; i++) @(posedge clk);
        check("timeout", W'(q.size()), '0);
        q.delete();
    endtask

    task automatic run_vec(string name, logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b,
                           logic [W-1:0] r, int l);
        int t;
        issue(o, a, b, t);
        wait_idle();
        check({name, "_res"}, dut_res, r);
        check({name, "_lat"}, W'(done_cyc - t), W'(l));
    endtask

    initial begin
        int t, t2;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        run_vec("divu_100_7", 2'b01, 100, 7, 14, 33);
        run_vec("div_m7_2", 2'b00, -32'sd7, 2, 32'hFFFF_FFFD, 33);
        run_vec("rem_m7_2", 2'b10, -32'sd7, 2, 32'hFFFF_FFFF, 33);
        run_vec("div_7_m2", 2'b00, 7, -32'sd2, 32'hFFFF_FFFD, 33);
        run_vec("rem_7_m2", 2'b10, 7, -32'sd2, 1, 33);
        run_vec("div_5_0", 2'b00, 5, 0, 32'hFFFF_FFFF, 1);
        run_vec("remu_5_0", 2'b11, 5, 0, 5, 1);
        run_vec("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_vec("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
        run_vec("divu_big", 2'b01, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 33);
        run_vec("divu_3_10", 2'b01, 3, 10, 0, EO_LAT);
        run_vec("rem_m3_10", 2'b10, -32'sd3, 10, 32'hFFFF_FFFD, EO_LAT);
        run_vec("remu_100_7", 2'b11, 100, 7, 2, 33);
        // flush mid-operation: no done, result keeps 2
        issue(2'b01, 1000, 3, t);
        repeat (9) @(posedge clk);
        #2;
        flush = 1;
        q[0].fl = cyc;
        @(posedge clk);
        #2 flush = 0;
        repeat (3) @(posedge clk);
        #2;
        check("flush_hold", result, 2);
        check("flush_idle", W'(ready), 1);
        run_vec("after_flush", 2'b01, 1000, 3, 333, 33);
        // flush beats a simultaneous start
        @(posedge clk);
        #2;
        start = 1;
        flush = 1;
        op = 2'b01;
        dividend = 50;
        divisor = 5;
        @(posedge clk);
        #2;
        start = 0;
        flush = 0;
        check("flush_start_ready", W'(ready), 1);
        check("flush_start_busy", W'(busy), 0);
        // back-to-back: second start lands in the DONE cycle of the first
        issue(2'b01, 100, 7, t);
        repeat (W - 1) @(posedge clk);
        issue(2'b11, 1000, 3, t2);
        wait_idle();
        check("b2b_res", dut_res, 1);
        check("b2b_lat", W'(done_cyc - t2), 33);
        // reset mid-busy
        issue(2'b01, 1000, 3, t);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 0;
        q.delete();
        last_res = 0;
        #1;
        check("rst_ready", W'(ready), 1);
        check("rst_done", W'(done), 0);
        check("rst_result", result, 0);
        @(posedge clk);
        #2 rst_n = 1;
        run_vec("after_rst", 2'b00, -32'sd100, 7, -32'sd14, 33);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1, "watchdog");
    end
endmodule
